// File: rtl/gates_sweep_checker.sv
// rtl/gates_sweep_checker.sv - power-on self-test sweep for the two-input gate bank
// Steps a/b through 00..11, samples y1..y6 after SETTLE cycles and accumulates mismatches.
module gates_sweep_checker #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             y5,
  input  logic             y6,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [5:0]       fail_mask
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int SW = ERR_W + 3;
  localparam logic [SW-1:0] ERR_MAX = (SW'(1) << ERR_W) - SW'(1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [5:0]       mask_q, mask_d;

  logic [5:0]       y_obs;
  logic [5:0]       y_exp;
  logic [5:0]       mm;
  logic [2:0]       mm_cnt;
  logic [SW-1:0]    err_sum;

  // Expected bank response for the vector currently applied (idx drives a/b).
  always_comb begin
    y_obs  = {y6, y5, y4, y3, y2, y1};
    y_exp  = {~(idx_q[1] ^ idx_q[0]), ~(idx_q[1] | idx_q[0]), ~(idx_q[1] & idx_q[0]),
              idx_q[1] ^ idx_q[0], idx_q[1] | idx_q[0], idx_q[1] & idx_q[0]};
    mm     = y_obs ^ y_exp;
    mm_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      mm_cnt = mm_cnt + 3'(mm[i]);
    end
    err_sum = SW'(err_q) + SW'(mm_cnt);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          wait_d  = SETTLE_LD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_q <= CW'(1)) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end

      S_CHECK: begin
        mask_d = mask_q | mm;
        // Sum is ERR_W+3 bits wide so it cannot wrap before the clamp.
        err_d  = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          wait_d  = SETTLE_LD;
          state_d = S_WAIT;
        end else begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// tb/tb_gates_sweep_checker.sv - self-checking bench for gates_sweep_checker
// Three instances: (SETTLE=1,ERR_W=5), (SETTLE=1,ERR_W=3), (SETTLE=3,ERR_W=5) with a faultable gate bank.
module tb_gates_sweep_checker;

  typedef enum int {K_GOOD, K_Y1SA0, K_SWAP36, K_ALLSA0, K_XMASK} kind_e;

  typedef struct {
    int    inst;
    kind_e k;
    int    exp_err;
    int    exp_mask;
    int    exp_pass;
  } row_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start   [3];
  logic [5:0] y_v     [3];
  logic       a_o     [3];
  logic       b_o     [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       pass_o  [3];
  logic [5:0] fm_o    [3];
  logic [4:0] ec0, ec2;
  logic [2:0] ec1;

  kind_e      kind    [3];
  logic [5:0] xmask   [3][4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] ideal(logic va, logic vb);
    return {~(va ^ vb), ~(va | vb), ~(va & vb), va ^ vb, va | vb, va & vb};
  endfunction

  function automatic logic [5:0] bank(kind_e k, logic va, logic vb, logic [5:0] xm);
    logic [5:0] g;
    g = ideal(va, vb);
    case (k)
      K_Y1SA0:  g[0] = 1'b0;
      K_SWAP36: g = {g[2], g[4], g[3], g[5], g[1], g[0]};
      K_ALLSA0: g = 6'b0;
      K_XMASK:  g = g ^ xm;
      default:  g = g;
    endcase
    return g;
  endfunction

  // Instance 2 sees garbage outputs for two cycles after every a/b change.
  for (genvar g = 0; g < 3; g++) begin : g_bank
    int         age = 100;
    logic [1:0] last_ab = 2'b00;
    always @(negedge clk) begin
      if ({a_o[g], b_o[g]} != last_ab) begin
        last_ab <= {a_o[g], b_o[g]};
        age     <= 0;
      end else if (age < 100) begin
        age <= age + 1;
      end
    end
    assign y_v[g] = bank(kind[g], a_o[g], b_o[g], xmask[g][{a_o[g], b_o[g]}])
                    ^ (((g == 2) && (age < 2)) ? 6'h3f : 6'h00);
  end

  gates_sweep_checker #(.SETTLE(1), .ERR_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .y1(y_v[0][0]), .y2(y_v[0][1]), .y3(y_v[0][2]), .y4(y_v[0][3]), .y5(y_v[0][4]), .y6(y_v[0][5]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_cnt(ec0), .fail_mask(fm_o[0])
  );

  gates_sweep_checker #(.SETTLE(1), .ERR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .y1(y_v[1][0]), .y2(y_v[1][1]), .y3(y_v[1][2]), .y4(y_v[1][3]), .y5(y_v[1][4]), .y6(y_v[1][5]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_cnt(ec1), .fail_mask(fm_o[1])
  );

  gates_sweep_checker #(.SETTLE(3), .ERR_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .y1(y_v[2][0]), .y2(y_v[2][1]), .y3(y_v[2][2]), .y4(y_v[2][3]), .y5(y_v[2][4]), .y6(y_v[2][5]),
    .a(a_o[2]), .b(b_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_cnt(ec2), .fail_mask(fm_o[2])
  );

  function automatic int errv(int i);
    if (i == 0) return int'(ec0);
    if (i == 1) return int'(ec1);
    return int'(ec2);
  endfunction

  function automatic int settle_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int errw_of(int i);
    return (i == 1) ? 3 : 5;
  endfunction

  // All outputs packed into one number so a reset check is a single comparison.
  function automatic int outs(int i);
    return (errv(i) << 11) | (int'(fm_o[i]) << 5) | (int'(a_o[i]) << 4) | (int'(b_o[i]) << 3)
           | (int'(busy_o[i]) << 2) | (int'(done_o[i]) << 1) | int'(pass_o[i]);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the four vectors, count raw mismatched bits, clamp to the counter range.
  task automatic ref_sweep(int i, output int e, output int m);
    int raw;
    int cap;
    logic [5:0] diff;
    logic [5:0] acc;
    logic va, vb;
    raw = 0;
    acc = '0;
    for (int v = 0; v < 4; v++) begin
      va   = ((v >> 1) & 1) != 0;
      vb   = (v & 1) != 0;
      diff = bank(kind[i], va, vb, xmask[i][v]) ^ ideal(va, vb);
      acc  = acc | diff;
      raw += $countones(diff);
    end
    cap = (1 << errw_of(i)) - 1;
    e   = (raw > cap) ? cap : raw;
    m   = int'(acc);
  endtask

  task automatic run_sweep(int i, int exp_err, int exp_mask, int exp_pass, string tag);
    int k;
    int ab_bad;
    int s;
    int exp_ab;
    bit got;
    s = settle_of(i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    chk({tag, "_accept_busy"}, int'(busy_o[i]), 1);
    chk({tag, "_accept_clear"}, errv(i) + int'(fm_o[i]) + int'(pass_o[i]), 0);
    k = 0;
    ab_bad = 0;
    got = 0;
    while (k < 200 && !got) begin
      exp_ab = (k < 4 * (s + 1)) ? k / (s + 1) : 0;
      if ({a_o[i], b_o[i]} != 2'(exp_ab)) ab_bad++;
      if (done_o[i]) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk({tag, "_done_latency"}, got ? k : -1, 4 * (s + 1));
    chk({tag, "_ab_sequence_errors"}, ab_bad, 0);
    chk({tag, "_err_cnt"}, errv(i), exp_err);
    chk({tag, "_fail_mask"}, int'(fm_o[i]), exp_mask);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, int'(done_o[i]) + int'(busy_o[i]), 0);
    chk({tag, "_pass"}, int'(pass_o[i]), exp_pass);
  endtask

  row_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int m;
    int dcnt;
    int dbad;

    tbl[0] = '{0, K_GOOD,   0,  6'h00, 1};
    tbl[1] = '{0, K_Y1SA0,  1,  6'h01, 0};
    tbl[2] = '{0, K_SWAP36, 8,  6'h24, 0};
    tbl[3] = '{0, K_ALLSA0, 12, 6'h3f, 0};
    tbl[4] = '{1, K_ALLSA0, 7,  6'h3f, 0};
    tbl[5] = '{1, K_GOOD,   0,  6'h00, 1};
    tbl[6] = '{2, K_GOOD,   0,  6'h00, 1};
    tbl[7] = '{2, K_Y1SA0,  1,  6'h01, 0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      kind[i]  = K_GOOD;
      for (int v = 0; v < 4; v++) xmask[i][v] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outputs_%0d", i), outs(i), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++) begin
      kind[tbl[r].inst] = tbl[r].k;
      run_sweep(tbl[r].inst, tbl[r].exp_err, tbl[r].exp_mask, tbl[r].exp_pass,
                $sformatf("row%0d", r));
    end

    // Results hold while idle.
    repeat (4) @(posedge clk);
    #1;
    chk("hold_results", (errv(2) << 8) | (int'(fm_o[2]) << 1) | int'(pass_o[2]), (1 << 8) | 2);

    for (int it = 0; it < 24; it++) begin
      int inst;
      inst = (it % 3 == 2) ? 1 : 0;
      kind[inst] = K_XMASK;
      for (int v = 0; v < 4; v++) begin
        xmask[inst][v] = (it % 4 == 0 || $urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom);
      end
      ref_sweep(inst, e, m);
      run_sweep(inst, e, m, (e == 0) ? 1 : 0, $sformatf("rand%0d", it));
    end

    // start held high: back-to-back sweeps, each accept clearing old results.
    kind[0] = K_ALLSA0;
    run_sweep(0, 12, 6'h3f, 0, "pre_held");
    kind[0] = K_GOOD;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    dbad = 0;
    for (int k = 0; k <= 32; k++) begin
      if (done_o[0] != ((k == 8) || (k == 18) || (k == 28))) dbad++;
      if (k == 0) chk("held_clear_first", errv(0) + int'(fm_o[0]), 0);
      if (k == 9) begin
        chk("held_gap_idle", int'(busy_o[0]), 0);
        chk("held_first_pass", int'(pass_o[0]), 1);
        kind[0] = K_ALLSA0;
      end
      if (k == 19) chk("held_second_err", (errv(0) << 1) | int'(pass_o[0]), 12 << 1);
      if (k == 20) begin
        chk("held_third_clear", (errv(0) << 1) | int'(busy_o[0]), 1);
        start[0] = 1'b0;
      end
      if (k == 31) chk("held_stops", int'(busy_o[0]), 0);
      @(posedge clk);
      #1;
    end
    chk("held_done_positions", dbad, 0);

    // start pulsed mid-sweep is ignored and not queued.
    kind[0] = K_Y1SA0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    dbad = 0;
    for (int k = 0; k <= 14; k++) begin
      if (k == 3) start[0] = 1'b1;
      if (k == 4) start[0] = 1'b0;
      if (done_o[0] != (k == 8)) dbad++;
      if (k >= 9 && busy_o[0]) dbad++;
      @(posedge clk);
      #1;
    end
    chk("midpulse_ignored", dbad, 0);
    chk("midpulse_err", errv(0), 1);

    // Reset during vector 2 abandons the sweep.
    kind[0] = K_ALLSA0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_vector2", {a_o[0], b_o[0]}, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", outs(0), 0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      dcnt += int'(done_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dbad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      dcnt += int'(done_o[0]);
      if (outs(0) != 0) dbad++;
    end
    chk("midreset_no_done", dcnt, 0);
    chk("midreset_stays_idle", dbad, 0);
    kind[0] = K_GOOD;
    run_sweep(0, 0, 0, 1, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
